// File: rtl/rns_mod_alu_pkg.sv
// rns_mod_alu_pkg: RNS moduli, Barrett constants and op encoding shared by rns_mod_alu.
package rns_mod_alu_pkg;
  localparam int NPRIMES = 2;
  localparam int COEFF_W = 8;
  localparam int TAG_W = (NPRIMES > 1) ? $clog2(NPRIMES) : 1;
  localparam int MU_W = 2 * COEFF_W + 1;
  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [MU_W-1:0] mu_t;
  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } rns_op_e;
  localparam coeff_t PRIMES [NPRIMES] = '{8'd17, 8'd97};
  // floor(2^(2*COEFF_W)/q), sized so that even the smallest modulus fits
  localparam mu_t MU [NPRIMES] = '{17'd3855, 17'd675};
  localparam tag_t LAST_TAG = tag_t'(NPRIMES - 1);
endpackage

// File: rtl/rns_mod_alu_mod_reduce_barrett.sv
// mod_reduce_barrett: two-stage a*b mod q (product and quotient estimate, then subtract and correct).
module mod_reduce_barrett
  import rns_mod_alu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  coeff_t i_a,
  input  coeff_t i_b,
  input  tag_t   i_tag,
  output coeff_t o_res
);
  localparam int PW = 2 * COEFF_W;
  localparam int XW = PW + MU_W;
  localparam int RW = COEFF_W + 1;
  logic [PW-1:0] w_p, r_p;
  logic [XW-1:0] w_x;
  mu_t w_t, r_t;
  tag_t r_tag;
  logic [RW-1:0] w_q, w_r;
  assign w_p = PW'(i_a) * PW'(i_b);
  assign w_x = XW'(w_p) * XW'(MU[i_tag]);
  assign w_t = mu_t'(w_x >> PW);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p   <= '0;
      r_t   <= '0;
      r_tag <= '0;
    end else begin
      r_p   <= w_p;
      r_t   <= w_t;
      r_tag <= i_tag;
    end
  end
  // the true remainder is below 2q, so arithmetic modulo 2^RW is exact
  assign w_q = RW'(PRIMES[r_tag]);
  assign w_r = RW'(r_p) - RW'(r_t) * w_q;
  assign o_res = coeff_t'(w_r >= w_q ? w_r - w_q : w_r);
endmodule

// File: rtl/rns_mod_alu.sv
// rns_mod_alu: 3-stage per-prime modular COPY/ADD/SUB/MUL on residue streams.
// Optional operand range check: define RNS_MOD_ALU_RANGE_CHECK_EN.
module rns_mod_alu
  import rns_mod_alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start_operation,
  input  logic [1:0]   op_sel,
  input  logic         source0_valid,
  input  coeff_t       source0_coefficient,
  input  logic         source0_last,
  input  logic         source1_valid,
  input  coeff_t       source1_coefficient,
  input  logic         source1_last,
  output logic         destination_valid,
  output coeff_t       destination_coefficient,
  output logic         destination_last,
  output logic         busy,
  output logic         op_error
);
  localparam int AW = COEFF_W + 1;
  rns_op_e r_op, w_op;
  tag_t r_cnt, w_cnt;
  logic w_bin, w_acc, w_err, w_range_err;
  logic r_busy, r_err;
  logic r_s1_v, r_s1_last;
  rns_op_e r_s1_op;
  tag_t r_s1_tag;
  coeff_t r_s1_a, r_s1_b;
  logic r_s2_v, r_s2_last;
  rns_op_e r_s2_op;
  tag_t r_s2_tag;
  logic [AW-1:0] r_s2_arith, w_q3, w_add, w_sub;
  coeff_t w_mul, w_res;
  logic r_out_v, r_out_last;
  coeff_t r_out_coef;
  // a beat arriving with start_operation already belongs to the new op at prime 0
  assign w_op  = start_operation ? rns_op_e'(op_sel) : r_op;
  assign w_cnt = start_operation ? '0 : r_cnt;
  assign w_bin = w_op != OP_COPY;
  assign w_acc = source0_valid & (~w_bin | source1_valid);
`ifdef RNS_MOD_ALU_RANGE_CHECK_EN
  assign w_range_err = w_acc & ((source0_coefficient >= PRIMES[w_cnt]) |
                                (w_bin & (source1_coefficient >= PRIMES[w_cnt])));
`else
  assign w_range_err = 1'b0;
`endif
  assign w_err = (w_bin & (source0_valid ^ source1_valid)) |
                 (w_acc & w_bin & (source0_last ^ source1_last)) |
                 (w_acc & source0_last & (w_cnt != LAST_TAG)) |
                 w_range_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= OP_COPY;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_op   <= w_op;
      r_cnt  <= w_acc ? ((w_cnt == LAST_TAG) ? '0 : w_cnt + tag_t'(1)) : w_cnt;
      r_err  <= (r_err & ~start_operation) | w_err;
      r_busy <= start_operation | (r_busy & ~(r_out_v & r_out_last));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v     <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_op    <= OP_COPY;
      r_s1_tag   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_v     <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_op    <= OP_COPY;
      r_s2_tag   <= '0;
      r_s2_arith <= '0;
      r_out_v    <= 1'b0;
      r_out_last <= 1'b0;
      r_out_coef <= '0;
    end else begin
      r_s1_v     <= w_acc;
      r_s1_last  <= source0_last;
      r_s1_op    <= w_op;
      r_s1_tag   <= w_cnt;
      r_s1_a     <= source0_coefficient;
      r_s1_b     <= source1_coefficient;
      r_s2_v     <= r_s1_v;
      r_s2_last  <= r_s1_last;
      r_s2_op    <= r_s1_op;
      r_s2_tag   <= r_s1_tag;
      r_s2_arith <= (r_s1_op == OP_ADD) ? {1'b0, r_s1_a} + {1'b0, r_s1_b} :
                    (r_s1_op == OP_SUB) ? {1'b0, r_s1_a} - {1'b0, r_s1_b} : {1'b0, r_s1_a};
      r_out_v    <= r_s2_v;
      r_out_last <= r_s2_v & r_s2_last;
      r_out_coef <= r_s2_v ? w_res : '0;
    end
  end
  mod_reduce_barrett u_barrett (
    .clk   (clk),
    .reset (reset),
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_tag (r_s1_tag),
    .o_res (w_mul)
  );
  // SUB result is negative exactly when the extra top bit is set
  assign w_q3  = {1'b0, PRIMES[r_s2_tag]};
  assign w_add = (r_s2_arith >= w_q3) ? r_s2_arith - w_q3 : r_s2_arith;
  assign w_sub = r_s2_arith[COEFF_W] ? r_s2_arith + w_q3 : r_s2_arith;
  assign w_res = (r_s2_op == OP_ADD) ? w_add[COEFF_W-1:0] :
                 (r_s2_op == OP_SUB) ? w_sub[COEFF_W-1:0] :
                 (r_s2_op == OP_MUL) ? w_mul : r_s2_arith[COEFF_W-1:0];
  assign destination_valid       = r_out_v;
  assign destination_last        = r_out_last;
  assign destination_coefficient = r_out_coef;
  assign busy                    = r_busy;
  assign op_error                = r_err;
endmodule

// File: tb/tb_rns_mod_alu.sv
// tb_rns_mod_alu: directed and randomized residue streams checked against a plain modular-arithmetic reference.
`timescale 1ns/1ps
module tb_rns_mod_alu;
  import rns_mod_alu_pkg::*;
  logic clk = 1'b0;
  logic reset, start_operation;
  logic [1:0] op_sel;
  logic source0_valid, source0_last, source1_valid, source1_last;
  coeff_t source0_coefficient, source1_coefficient;
  logic destination_valid, destination_last, busy, op_error;
  coeff_t destination_coefficient;
  always #5 clk = ~clk;
  rns_mod_alu dut (
    .clk                     (clk),
    .reset                   (reset),
    .start_operation         (start_operation),
    .op_sel                  (op_sel),
    .source0_valid           (source0_valid),
    .source0_coefficient     (source0_coefficient),
    .source0_last            (source0_last),
    .source1_valid           (source1_valid),
    .source1_coefficient     (source1_coefficient),
    .source1_last            (source1_last),
    .destination_valid       (destination_valid),
    .destination_coefficient (destination_coefficient),
    .destination_last        (destination_last),
    .busy                    (busy),
    .op_error                (op_error)
  );
  typedef struct {
    int due;
    int coef;
    bit last;
  } exp_t;
  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int edge_n = 0;
  int m_op = 0;
  int m_cnt = 0;
  bit m_err = 0;
  bit m_busy = 0;
  bit m_out_vl = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask
  function automatic int ref_res(input int op, input int a, input int b, input int qm);
    case (op)
      1: return (a + b) % qm;
      2: return (a - b + qm) % qm;
      3: return (a * b) % qm;
      default: return a;
    endcase
  endfunction
  // drive one cycle of inputs, advance the reference, then check outputs mid-cycle
  task automatic step(input bit rst, input bit st, input int op, input bit v0, input int a,
                      input bit l0, input bit v1, input int b, input bit l1);
    int ope, cnt;
    bit bin, acc, err, ev;
    exp_t e;
    reset = rst;
    start_operation = st;
    op_sel = 2'(op);
    source0_valid = v0;
    source0_coefficient = COEFF_W'(a);
    source0_last = l0;
    source1_valid = v1;
    source1_coefficient = COEFF_W'(b);
    source1_last = l1;
    if (rst) begin
      m_op = 0;
      m_cnt = 0;
      m_err = 0;
      m_busy = 0;
      exp_q.delete();
    end else begin
      ope = st ? op : m_op;
      cnt = st ? 0 : m_cnt;
      bin = ope != 0;
      acc = v0 && (!bin || v1);
      err = (bin && (v0 != v1)) || (acc && bin && (l0 != l1)) || (acc && l0 && cnt != NPRIMES - 1);
`ifdef RNS_MOD_ALU_RANGE_CHECK_EN
      err = err || (acc && (a >= int'(PRIMES[cnt]) || (bin && b >= int'(PRIMES[cnt]))));
`endif
      m_busy = st || (m_busy && !m_out_vl);
      m_err = (m_err && !st) || err;
      m_op = ope;
      m_cnt = cnt;
      if (acc) begin
        e.coef = ref_res(ope, a, b, int'(PRIMES[cnt]));
        e.last = l0;
        e.due = edge_n + 3;
        exp_q.push_back(e);
        m_cnt = (cnt + 1) % NPRIMES;
      end
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
    chk("dest_valid", destination_valid, ev);
    if (ev) begin
      chk("dest_coef", destination_coefficient, exp_q[0].coef);
      chk("dest_last", destination_last, exp_q[0].last);
      m_out_vl = exp_q[0].last;
      void'(exp_q.pop_front());
    end else begin
      m_out_vl = 0;
      if (rst) begin
        chk("reset_coef", destination_coefficient, 0);
        chk("reset_last", destination_last, 0);
      end
    end
    chk("op_error", op_error, m_err);
    chk("busy", busy, m_busy);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic start(input int op);
    step(0, 1, op, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic beat(input int a, input int b, input bit l);
    step(0, 0, 0, 1, a, l, 1, b, l);
  endtask
  initial begin
    int op, n, a, b, p;
    bit st, l;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    start(1);
    beat(10, 9, 0);
    beat(90, 20, 1);
    idle(5);
    start(2);
    beat(3, 5, 0);
    beat(0, 96, 1);
    idle(5);
    start(3);
    beat(16, 16, 0);
    beat(96, 96, 1);
    idle(5);
    start(3);
    for (int i = 0; i < 97 * 97; i++) begin
      beat((i % 289) % 17, (i % 289) / 17, 0);
      beat(i % 97, i / 97, i == 97 * 97 - 1);
    end
    idle(5);
    start(1);
    step(0, 0, 0, 1, 5, 0, 0, 0, 0);
    idle(4);
    start(1);
    idle(2);
    for (int k = 0; k < 6; k++) begin
      op = $urandom_range(0, 3);
      n = $urandom_range(2, 6);
      for (int c = 0; c < n; c++) begin
        for (p = 0; p < NPRIMES; p++) begin
          st = (c == 0) && (p == 0);
          l = (c == n - 1) && (p == NPRIMES - 1);
          a = $urandom_range(0, int'(PRIMES[p]) - 1);
          b = $urandom_range(0, int'(PRIMES[p]) - 1);
          if (!st && $urandom_range(0, 3) == 0) idle(1);
          step(0, st, op, 1, a, l, 1, b, l);
        end
      end
      idle(4);
    end
    start(1);
    beat(10, 9, 0);
    beat(90, 20, 1);
    step(0, 1, 0, 1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 50, 1, 0, 0, 0);
    idle(5);
    start(1);
    beat(1, 2, 0);
    beat(3, 4, 1);
    beat(5, 6, 0);
    step(1, 0, 0, 1, 7, 1, 1, 8, 1);
    idle(5);
    step(0, 1, 0, 1, 17, 0, 0, 0, 0);
    idle(4);
    start(0);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
